// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the MIPS core (port 0)
// and a secondary master (port 1). One owner per cycle, registered grants,
// combinational acks, and a bounded burst length while the other port waits.
// Optional feature macro: DMEM_ARB_CPU_PRIORITY_EN (port 0 wins ties and
// preempts port 1; port 0 is still limited by MAX_BURST against port 1).

module dmem_arbiter #(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          busy
);

`ifdef DMEM_ARB_CPU_PRIORITY_EN
   localparam bit CpuPriority = 1'b1;
`else
   localparam bit CpuPriority = 1'b0;
`endif

   localparam int unsigned  CW     = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CntMax = CW'(MAX_BURST);
   localparam logic [CW:0]   BurstLimit = (CW + 1)'(MAX_BURST);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;     // 1 = port 1 owned most recently
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   cnt_inc;
   logic          burst_done;
   logic          tie_to1;

   // The beat in flight is the last one this tenure may take while contended.
   assign cnt_inc    = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
   assign burst_done = (cnt_inc >= BurstLimit);
   assign tie_to1    = ~CpuPriority & ~last_q;

   // Next-state: ownership decision, tenure bookkeeping on entry, beat counting.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req0 && req1)  state_d = tie_to1 ? StOwn1 : StOwn0;
            else if (req0)     state_d = StOwn0;
            else if (req1)     state_d = StOwn1;
         end
         StOwn0: begin
            if (!req0)                    state_d = req1 ? StOwn1 : StIdle;
            else if (req1 && burst_done)  state_d = StOwn1;
         end
         StOwn1: begin
            if (!req1)                                   state_d = req0 ? StOwn0 : StIdle;
            else if (req0 && (burst_done || CpuPriority)) state_d = StOwn0;
         end
         default: state_d = StIdle;
      endcase

      if ((state_d != state_q) && (state_d != StIdle)) begin
         cnt_d  = '0;
         last_d = (state_d == StOwn1);
      end else if ((ack0 || ack1) && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous reset; reset drops any beat in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt0   = (state_q == StOwn0);
   assign gnt1   = (state_q == StOwn1);
   assign ack0   = gnt0 & req0;
   assign ack1   = gnt1 & req1;
   assign busy   = (state_q != StIdle);
   assign mem_we = (ack0 & we0) | (ack1 & we1);
   assign rdata0 = mem_rd;
   assign rdata1 = mem_rd;

   // Memory address/data mux: owner's values, zero when nobody owns the memory.
   always_comb begin
      mem_a  = '0;
      mem_wd = '0;
      if (gnt0) begin
         mem_a  = addr0;
         mem_wd = wdata0;
      end else if (gnt1) begin
         mem_a  = addr1;
         mem_wd = wdata1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// two-master traffic against a behavioural ownership/memory model.

module tb_dmem_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int          MAXB = 4;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, ack0, ack1, mem_we, busy;
   logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
   logic [AW-1:0] mem_a;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .busy(busy)
   );

   // Word-addressed data memory with combinational read.
   logic [DW-1:0] tbmem [256];
   always @(posedge clk) if (mem_we) tbmem[mem_a[9:2]] <= mem_wd;
   assign mem_rd = tbmem[mem_a[9:2]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
   endtask

   // Leaves the bench in the first cycle after reset release, arbiter idle.
   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #1;
      vectors++;
      if ({gnt0, gnt1, busy, mem_we} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0000", {gnt0, gnt1, busy, mem_we});
      end
      vectors++;
      if ({mem_a, mem_wd} !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: got a=%h wd=%h expected 0", mem_a, mem_wd);
      end
      step();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++;
         if ({gnt0, gnt1, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 000", {gnt0, gnt1, busy});
         end
      end
   endtask

   task automatic test_async_reset_midburst();
      apply_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h11;
      step();
      step();
      #1;
      vectors++;
      if ({gnt1, ack1, busy} !== 3'b111) begin
         miscompares++;
         $display("FAIL midburst_own1: got %b expected 111", {gnt1, ack1, busy});
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({gnt0, gnt1, mem_we, busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset: got %b expected 0000", {gnt0, gnt1, mem_we, busy});
      end
      req1 = 1'b0; we1 = 1'b0;
      step();
      #2 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         vectors++;
         if ({gnt0, gnt1, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected 000", {gnt0, gnt1, busy});
         end
      end
   endtask

   task automatic test_single_write_read();
      apply_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h54; wdata0 = 32'h7;
      step();
      vectors++;
      if ({gnt0, ack0, mem_we} !== 3'b111) begin
         miscompares++;
         $display("FAIL write_ack: got %b expected 111", {gnt0, ack0, mem_we});
      end
      vectors++;
      if (mem_a !== 32'h54 || mem_wd !== 32'h7) begin
         miscompares++;
         $display("FAIL write_bus: got a=%h wd=%h expected a=54 wd=7", mem_a, mem_wd);
      end
      step();
      we0 = 1'b0;
      #1;
      vectors++;
      if (ack0 !== 1'b1 || mem_we !== 1'b0 || rdata0 !== 32'h7) begin
         miscompares++;
         $display("FAIL read_back: got ack=%b we=%b rd=%h expected 1 0 7", ack0, mem_we, rdata0);
      end
      step();
      req0 = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      logic e0, e1;
      apply_reset();
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 32'h200; addr1 = 32'h204;
      for (int c = 1; c <= 9; c++) begin
         step();
         e0 = (c <= 4) || (c == 9);
         e1 = (c >= 5) && (c <= 8);
         vectors++;
         if (ack0 !== e0 || ack1 !== e1) begin
            miscompares++;
            $display("FAIL rr_cycle%0d: got ack0=%b ack1=%b expected %b %b", c, ack0, ack1, e0, e1);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_release_idle();
      apply_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h60; wdata0 = 32'h5A;
      for (int c = 1; c <= 2; c++) begin
         step();
         vectors++;
         if (ack0 !== 1'b1) begin
            miscompares++;
            $display("FAIL release_beat%0d: got %b expected 1", c, ack0);
         end
      end
      step();
      req0 = 1'b0;
      #1;
      vectors++;
      if ({gnt0, ack0, mem_we} !== 3'b100) begin
         miscompares++;
         $display("FAIL release_drop: got %b expected 100", {gnt0, ack0, mem_we});
      end
      step();
      vectors++;
      if ({gnt0, busy, mem_we} !== 3'b000) begin
         miscompares++;
         $display("FAIL release_idle: got %b expected 000", {gnt0, busy, mem_we});
      end
   endtask

   task automatic test_coherence();
      int we_cycles;
      bit seen;
      apply_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'hDEADBEEF;
      step();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80;
      #1;
      vectors++;
      if (ack1 !== 1'b1 || mem_a !== 32'h80 || mem_wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL coh_write: got ack1=%b a=%h wd=%h expected 1 80 deadbeef", ack1, mem_a,
                  mem_wd);
      end
      we_cycles = int'(mem_we);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         step();
         req1 = 1'b0; we1 = 1'b0;
         #1;
         we_cycles += int'(mem_we);
         if (ack0) begin
            seen = 1'b1;
            vectors++;
            if (rdata0 !== 32'hDEADBEEF) begin
               miscompares++;
               $display("FAIL coh_read: got %h expected deadbeef", rdata0);
            end
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL coh_ack0_timeout: got no ack0 expected ack0 within 8 cycles");
      end
      vectors++;
      if (we_cycles != 1) begin
         miscompares++;
         $display("FAIL coh_we_count: got %0d expected 1", we_cycles);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_priority();
      apply_reset();
      req1 = 1'b1; addr1 = 32'h100;
      step();
      vectors++;
      if (ack1 !== 1'b1) begin
         miscompares++;
         $display("FAIL prio_own1: got %b expected 1", ack1);
      end
      step();
      req0 = 1'b1; addr0 = 32'h104;
      #1;
      vectors++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_cycle_k: got ack0=%b ack1=%b expected 0 1", ack0, ack1);
      end
      step();
      vectors++;
      if ({gnt0, ack0, ack1} !== 3'b110) begin
         miscompares++;
         $display("FAIL prio_preempt: got %b expected 110", {gnt0, ack0, ack1});
      end
      idle_inputs();
      step();
      step();
      req0 = 1'b1; req1 = 1'b1;
      step();
      vectors++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_tie: got ack0=%b ack1=%b expected 1 0", ack0, ack1);
      end
      idle_inputs();
      step();
   endtask

   // Random traffic. Model: who owns the memory, who owned it last, and how
   // many beats the current owner has taken; plus a sparse memory image.
   task automatic test_random();
      int owner, last, beats, nxt, o, y;
      logic [1:0] rq, acked;
      logic e0, e1, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic [DW-1:0] mdata [256];
      bit mvalid [256];
      for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
      apply_reset();
      owner = -1; last = 1; beats = 0; acked = 2'b00;
      for (int n = 0; n < 3000; n++) begin
         if (!req0 || acked[0]) begin
            req0 = ($urandom_range(0, 9) < 7);
            we0 = 1'($urandom_range(0, 1));
            addr0 = AW'((64 + $urandom_range(0, 191)) * 4);
            wdata0 = $urandom;
         end
         if (!req1 || acked[1]) begin
            req1 = ($urandom_range(0, 9) < 7);
            we1 = 1'($urandom_range(0, 1));
            addr1 = AW'((64 + $urandom_range(0, 191)) * 4);
            wdata1 = $urandom;
         end
         #1;
         e0 = (owner == 0) && req0;
         e1 = (owner == 1) && req1;
         ewe = (e0 && we0) || (e1 && we1);
         ea = (owner == 0) ? addr0 : (owner == 1) ? addr1 : '0;
         ewd = (owner == 0) ? wdata0 : (owner == 1) ? wdata1 : '0;
         vectors++;
         if (ack0 !== e0 || ack1 !== e1) begin
            miscompares++;
            $display("FAIL rnd_ack n=%0d: got %b%b expected %b%b", n, ack0, ack1, e0, e1);
         end
         vectors++;
         if (gnt0 !== (owner == 0) || gnt1 !== (owner == 1) || busy !== (owner >= 0)) begin
            miscompares++;
            $display("FAIL rnd_gnt n=%0d: got %b%b%b expected owner %0d", n, gnt0, gnt1, busy,
                     owner);
         end
         vectors++;
         if (mem_we !== ewe || mem_a !== ea || mem_wd !== ewd) begin
            miscompares++;
            $display("FAIL rnd_bus n=%0d: got we=%b a=%h wd=%h expected %b %h %h", n, mem_we,
                     mem_a, mem_wd, ewe, ea, ewd);
         end
         if (e0 && !we0 && mvalid[addr0[9:2]]) begin
            vectors++;
            if (rdata0 !== mdata[addr0[9:2]]) begin
               miscompares++;
               $display("FAIL rnd_rdata0 n=%0d: got %h expected %h", n, rdata0,
                        mdata[addr0[9:2]]);
            end
         end
         if (e1 && !we1 && mvalid[addr1[9:2]]) begin
            vectors++;
            if (rdata1 !== mdata[addr1[9:2]]) begin
               miscompares++;
               $display("FAIL rnd_rdata1 n=%0d: got %h expected %h", n, rdata1,
                        mdata[addr1[9:2]]);
            end
         end
         if (ewe) begin
            mdata[ea[9:2]] = ewd;
            mvalid[ea[9:2]] = 1'b1;
         end
         acked = {e1, e0};
         rq = {req1, req0};
         step();
         // Ownership for the next cycle, from this cycle's requests.
         if (owner < 0) begin
            if (rq == 2'b11)  nxt = PRIO ? 0 : 1 - last;
            else if (rq[0])   nxt = 0;
            else if (rq[1])   nxt = 1;
            else              nxt = -1;
         end else begin
            o = owner;
            y = 1 - owner;
            if (!rq[o])                                          nxt = rq[y] ? y : -1;
            else if (rq[y] && (beats + 1 >= MAXB || (PRIO && o == 1))) nxt = y;
            else                                                 nxt = o;
         end
         if (nxt >= 0 && nxt == owner) begin
            beats++;
         end else if (nxt >= 0) begin
            beats = 0;
            last = nxt;
         end
         owner = nxt;
      end
      idle_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_single_write_read();
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      test_round_robin();
`else
      test_priority();
`endif
      test_release_idle();
      test_coherence();
      test_async_reset_midburst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
